core_fma_quire_acc: RTL and testbench

Fixed-point accumulation stage of the PPU fused multiply-add path. It sits directly downstream of the FMA multiplier.
- Consumes the un-normalised product FIR (sign, total exponent, `MANT_MUL_RESULT_SIZE`-bit mantissa) and the addend FIR.
- Accumulates products into an `FX_B`-bit two's-complement fixed-point register.
- Emits the running sum both as raw fixed point and as a normalised FIR for the posit encoder.
- Three-stage pipeline at full throughput, with sticky saturation tracking.

---
 rtl/ppu_pkg.sv | 27 ++
 rtl/fir_to_fixed.sv | 58 +++++
 rtl/core_fma_quire_acc.sv | 191 +++++++++++++++++++
 tb/tb_core_fma_quire_acc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and default sizes for the posit processing unit datapath.
package ppu_pkg;

  localparam int N                    = 16;
  localparam int TE_BITS              = 7;
  localparam int MANT_SIZE            = N - 2;
  localparam int MANT_MUL_RESULT_SIZE = 2 * MANT_SIZE;
  localparam int FRAC_FULL_SIZE       = 40;
  localparam int FX_M                 = 31;
  localparam int FX_B                 = 64;

  // Signed total exponent (regime and exponent folded together).
  typedef logic signed [TE_BITS-1:0] exponent_t;

  // Un-normalised floating intermediate: mantissa carries one integer bit.
  typedef struct packed {
    logic                 sign;
    exponent_t            total_exponent;
    logic [MANT_SIZE-1:0] mant;
  } fir_t;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fir_to_fixed.sv
// Maps one sign/exponent/mantissa operand onto the signed fixed-point grid,
// saturating oversized values and flagging ones lost off the bottom.
module fir_to_fixed
  import ppu_pkg::*;
#(
  parameter int MANT_W   = MANT_SIZE,
  parameter int INT_BITS = 1,
  parameter int TE_W     = TE_BITS,
  parameter int FX_INT   = FX_M,
  parameter int FX_W     = FX_B
) (
  input  logic                   sign,
  input  logic signed [TE_W-1:0] te,
  input  logic [MANT_W-1:0]      mant,
  output logic [FX_W-1:0]        fixed,
  output logic                   trunc,
  output logic                   ovf
);

  localparam int FXF = FX_W - FX_INT;
  localparam int SHW = 16;
  localparam int EW  = FX_W + MANT_W;
  localparam logic [FX_W-1:0] MAX_MAG = {1'b0, {(FX_W-1){1'b1}}};

  logic signed [SHW-1:0] sh;
  logic [SHW-1:0]        rsh;
  logic [EW-1:0]         wide;
  logic [FX_W-1:0]       mag;

  // Position of the mantissa LSB relative to the fixed-point LSB.
  assign sh  = SHW'(FXF - (MANT_W - INT_BITS)) + SHW'(te);
  assign rsh = -sh;

  // Shift into place, saturate on overflow, then apply the sign.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    wide  = '0;
    mag   = '0;
    trunc = 1'b0;
    ovf   = 1'b0;
    if (!sh[SHW-1]) begin
      if (sh >= SHW'(FX_W - 1)) begin
        ovf = |mant;
      end else begin
        wide = EW'(mant) << sh;
        ovf  = |wide[EW-1:FX_W-1];
      end
      mag = ovf ? MAX_MAG : wide[FX_W-1:0];
    end else if (rsh >= SHW'(MANT_W)) begin
      trunc = |mant;
    end else begin
      mag   = FX_W'(mant >> rsh);
      trunc = |(mant & ~({MANT_W{1'b1}} << rsh));
    end
    fixed = sign ? -mag : mag;
  end

endmodule

// File: rtl/core_fma_quire_acc.sv
// Fixed-point accumulation stage of the FMA path: convert (S1), accumulate
// with saturation (S2), normalise back to sign/exponent/fraction (S3).
module core_fma_quire_acc #(
  parameter int N                    = ppu_pkg::N,
  parameter int TE_BITS              = ppu_pkg::TE_BITS,
  parameter int MANT_SIZE            = N - 2,
  parameter int MANT_MUL_RESULT_SIZE = 2 * MANT_SIZE,
  parameter int FRAC_FULL_SIZE       = ppu_pkg::FRAC_FULL_SIZE,
  parameter int FX_M                 = ppu_pkg::FX_M,
  parameter int FX_B                 = ppu_pkg::FX_B
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  input  logic                            start_i,
  input  logic                            prod_sign_i,
  input  logic signed [TE_BITS-1:0]       prod_te_i,
  input  logic [MANT_MUL_RESULT_SIZE-1:0] prod_mant_i,
  input  ppu_pkg::fir_t                   add_fir_i,
  output logic                            out_valid_o,
  output logic [FX_B-1:0]                 fixed_o,
  output logic                            sign_o,
  output ppu_pkg::exponent_t              te_o,
  output logic [FRAC_FULL_SIZE-1:0]       frac_o,
  output logic                            zero_o,
  output logic                            frac_truncated_o,
  output logic                            overflow_o
);

  localparam int FXF = FX_B - FX_M;
  localparam int PW  = $clog2(FX_B);
  localparam logic [FX_B-1:0] ACC_MAX = {1'b0, {(FX_B-1){1'b1}}};
  localparam logic [FX_B-1:0] ACC_MIN = {1'b1, {(FX_B-1){1'b0}}};

  // ---------------- S1: operand conversion ----------------
  logic [FX_B-1:0] prod_fx, add_fx;
  logic            prod_trunc, prod_ovf, add_trunc, add_ovf;

  fir_to_fixed #(
    .MANT_W  (MANT_MUL_RESULT_SIZE),
    .INT_BITS(2),
    .TE_W    (TE_BITS),
    .FX_INT  (FX_M),
    .FX_W    (FX_B)
  ) u_prod_cvt (
    .sign (prod_sign_i),
    .te   (prod_te_i),
    .mant (prod_mant_i),
    .fixed(prod_fx),
    .trunc(prod_trunc),
    .ovf  (prod_ovf)
  );

  fir_to_fixed #(
    .MANT_W  (MANT_SIZE),
    .INT_BITS(1),
    .TE_W    (TE_BITS),
    .FX_INT  (FX_M),
    .FX_W    (FX_B)
  ) u_add_cvt (
    .sign (add_fir_i.sign),
    .te   (add_fir_i.total_exponent),
    .mant (add_fir_i.mant),
    .fixed(add_fx),
    .trunc(add_trunc),
    .ovf  (add_ovf)
  );

  logic            s1_valid, s1_start, s1_trunc, s1_ovf;
  logic [FX_B-1:0] s1_prod, s1_add;

  // Register converted operands; the addend only contributes on a start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_prod  <= '0;
      s1_add   <= '0;
      s1_trunc <= 1'b0;
      s1_ovf   <= 1'b0;
    end else begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_start <= start_i;
        s1_prod  <= prod_fx;
        s1_add   <= start_i ? add_fx : '0;
        s1_trunc <= prod_trunc | (start_i & add_trunc);
        s1_ovf   <= prod_ovf | (start_i & add_ovf);
      end
    end
  end

  // ---------------- S2: accumulator FSM ----------------
  ppu_pkg::acc_state_e state_q, state_d;
  logic [FX_B-1:0]     acc_q, acc_d, base, sum_sat;
  logic [FX_B:0]       sum_ext;
  logic                ovf_q, ovf_d, trunc_q, trunc_d, s2_valid, fresh, sum_ovf;

  // A fresh sum starts from the addend instead of the old accumulator.
  assign fresh   = (state_q == ppu_pkg::EMPTY) || s1_start;
  assign base    = fresh ? s1_add : acc_q;
  assign sum_ext = {base[FX_B-1], base} + {s1_prod[FX_B-1], s1_prod};
  assign sum_ovf = sum_ext[FX_B] ^ sum_ext[FX_B-1];
  assign sum_sat = !sum_ovf ? sum_ext[FX_B-1:0] : (sum_ext[FX_B] ? ACC_MIN : ACC_MAX);

  // Next-state and accumulator update; stickies restart with each new sum.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    case (state_q)
      ppu_pkg::EMPTY:  if (s1_valid) state_d = ppu_pkg::ACTIVE;
      ppu_pkg::ACTIVE: state_d = ppu_pkg::ACTIVE;
      default:         state_d = ppu_pkg::EMPTY;
    endcase
    if (s1_valid) begin
      acc_d   = sum_sat;
      ovf_d   = (fresh ? 1'b0 : ovf_q) | s1_ovf | sum_ovf;
      trunc_d = (fresh ? 1'b0 : trunc_q) | s1_trunc;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ppu_pkg::EMPTY;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      trunc_q  <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      trunc_q  <= trunc_d;
      s2_valid <= s1_valid;
    end
  end

  // ---------------- S3: normalise ----------------
  logic [FX_B-1:0]           mag, norm;
  logic [PW-1:0]             lead;
  logic [FRAC_FULL_SIZE-1:0] frac_n;
  logic                      drop_n, zero_n;
  ppu_pkg::exponent_t        te_n;

  // Magnitude, leading-one position and left-justified magnitude.
  always_comb begin
    mag = acc_q;
    if (acc_q[FX_B-1]) mag = (acc_q == ACC_MIN) ? ACC_MAX : -acc_q;
    lead = '0;
    for (int i = 0; i < FX_B; i++) begin
      if (mag[i]) lead = PW'(i);
    end
    norm = mag << (PW'(FX_B - 1) - lead);
  end

  // The hidden bit sits at the top of norm; everything below is fraction.
  assign zero_n = !norm[FX_B-1];
  assign frac_n = norm[FX_B-2 -: FRAC_FULL_SIZE];
  assign drop_n = |norm[FX_B-2-FRAC_FULL_SIZE:0];
  assign te_n   = TE_BITS'(int'(lead) - FXF);

  // Output registers update only on a pulse and hold otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o      <= 1'b0;
      fixed_o          <= '0;
      sign_o           <= 1'b0;
      te_o             <= '0;
      frac_o           <= '0;
      zero_o           <= 1'b1;
      frac_truncated_o <= 1'b0;
      overflow_o       <= 1'b0;
    end else begin
      out_valid_o <= s2_valid;
      if (s2_valid) begin
        fixed_o          <= acc_q;
        sign_o           <= acc_q[FX_B-1];
        te_o             <= zero_n ? '0 : te_n;
        frac_o           <= frac_n;
        zero_o           <= zero_n;
        frac_truncated_o <= trunc_q | drop_n;
        overflow_o       <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_core_fma_quire_acc.sv
// Self-checking bench: rational-arithmetic reference model plus directed cases.
module tb_core_fma_quire_acc;
  import ppu_pkg::*;

  localparam int FXF = FX_B - FX_M;
  localparam logic signed [127:0] MAXS = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINS = -128'sh8000_0000_0000_0000;

  typedef struct {
    logic [63:0] fixed;
    logic        sign;
    logic [6:0]  te;
    logic [39:0] frac;
    logic        zero;
    logic        trunc;
    logic        ovf;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } pend_t;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               in_valid_i, start_i, prod_sign_i;
  logic signed [6:0]  prod_te_i;
  logic [27:0]        prod_mant_i;
  fir_t               add_fir_i;
  logic               out_valid_o, sign_o, zero_o, frac_truncated_o, overflow_o;
  logic [63:0]        fixed_o;
  exponent_t          te_o;
  logic [39:0]        frac_o;

  core_fma_quire_acc dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .in_valid_i      (in_valid_i),
    .start_i         (start_i),
    .prod_sign_i     (prod_sign_i),
    .prod_te_i       (prod_te_i),
    .prod_mant_i     (prod_mant_i),
    .add_fir_i       (add_fir_i),
    .out_valid_o     (out_valid_o),
    .fixed_o         (fixed_o),
    .sign_o          (sign_o),
    .te_o            (te_o),
    .frac_o          (frac_o),
    .zero_o          (zero_o),
    .frac_truncated_o(frac_truncated_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [127:0] m_acc;
  bit                  m_active, m_ovf, m_trunc;
  pend_t               pend[$];
  out_t                cur;
  out_t                seen[$];

  function automatic out_t reset_out();
    out_t o;
    o.fixed = '0; o.sign = 1'b0; o.te = '0; o.frac = '0;
    o.zero = 1'b1; o.trunc = 1'b0; o.ovf = 1'b0;
    return o;
  endfunction

  // value * 2^FXF = mant * 2^(te + FXF - frac_bits), kept as exact integer/fraction.
  function automatic void conv(input bit sgn, input int te, input int frac_bits,
                               input logic [63:0] mant, output logic signed [127:0] val,
                               output bit trunc, output bit ovf);
    logic [255:0] big;
    logic [127:0] ip;
    int e;
    e   = te + FXF - frac_bits;
    big = {64'b0, mant, 128'b0};
    if (e >= 0) big = big << e;
    else        big = big >> (-e);
    ip    = big[255:128];
    trunc = (big[127:0] != '0);
    ovf   = (ip > 128'(MAXS));
    if (ovf) ip = 128'(MAXS);
    val = sgn ? -$signed(ip) : $signed(ip);
  endfunction

  function automatic out_t expect_out(input logic signed [127:0] acc, input bit ovf, input bit tr);
    out_t o;
    logic [127:0] mag, rem, scaled, fr;
    int p;
    o.fixed = acc[63:0];
    o.ovf   = ovf;
    mag = (acc < 0) ? 128'(-acc) : 128'(acc);
    if (mag > 128'(MAXS)) mag = 128'(MAXS);
    if (mag == '0) begin
      o.sign = 1'b0; o.te = '0; o.frac = '0; o.zero = 1'b1; o.trunc = tr;
    end else begin
      p = 0;
      while ((mag >> (p + 1)) != '0) p++;
      rem    = mag - (128'd1 << p);
      scaled = rem << FRAC_FULL_SIZE;
      fr     = scaled >> p;
      o.sign  = (acc < 0);
      o.te    = 7'(p - FXF);
      o.frac  = fr[39:0];
      o.zero  = 1'b0;
      o.trunc = tr | ((fr << p) != scaled);
    end
    return o;
  endfunction

  task automatic model_step(input bit st, input bit ps, input logic signed [6:0] pte,
                            input logic [27:0] pm, input fir_t af);
    logic signed [127:0] pv, av, base, sum;
    bit pt, po, at, ao, fresh;
    pend_t e;
    conv(ps, int'(pte), 26, 64'(pm), pv, pt, po);
    if (st) conv(af.sign, int'(af.total_exponent), 13, 64'(af.mant), av, at, ao);
    else begin av = '0; at = 1'b0; ao = 1'b0; end
    fresh = !m_active || st;
    base  = fresh ? av : m_acc;
    if (fresh) begin m_ovf = po | ao; m_trunc = pt | at; end
    else begin m_ovf = m_ovf | po; m_trunc = m_trunc | pt; end
    sum = base + pv;
    if (sum > MAXS) begin sum = MAXS; m_ovf = 1'b1; end
    else if (sum < MINS) begin sum = MINS; m_ovf = 1'b1; end
    m_acc    = sum;
    m_active = 1'b1;
    e.cyc = cyc + 3;
    e.o   = expect_out(m_acc, m_ovf, m_trunc);
    pend.push_back(e);
  endtask

  task automatic reset_model();
    pend.delete();
    m_acc = '0; m_active = 1'b0; m_ovf = 1'b0; m_trunc = 1'b0;
    cur = reset_out();
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    bit   ev;
    out_t a;
    while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
    ev = (pend.size() > 0) && (pend[0].cyc == cyc);
    check("out_valid", out_valid_o, ev);
    if (ev) begin
      cur = pend[0].o;
      void'(pend.pop_front());
    end
    a.fixed = fixed_o; a.sign = sign_o; a.te = te_o; a.frac = frac_o;
    a.zero = zero_o; a.trunc = frac_truncated_o; a.ovf = overflow_o;
    if (out_valid_o) seen.push_back(a);
    check("fixed", a.fixed, cur.fixed);
    check("sign",  a.sign,  cur.sign);
    check("te",    a.te,    cur.te);
    check("frac",  a.frac,  cur.frac);
    check("zero",  a.zero,  cur.zero);
    check("trunc", a.trunc, cur.trunc);
    check("ovf",   a.ovf,   cur.ovf);
  end

  // ---------------- stimulus ----------------
  function automatic fir_t mkfir(input bit s, input int te, input logic [13:0] m);
    fir_t f;
    f.sign = s; f.total_exponent = 7'(te); f.mant = m;
    return f;
  endfunction

  task automatic drive(input bit v, input bit st, input bit ps, input logic signed [6:0] pte,
                       input logic [27:0] pm, input fir_t af);
    @(posedge clk_i); #1;
    in_valid_i = v; start_i = st; prod_sign_i = ps;
    prod_te_i = pte; prod_mant_i = pm; add_fir_i = af;
    if (v) model_step(st, ps, pte, pm, af);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  localparam logic [27:0] P_ONE = 28'h400_0000;  // 1.0 with two integer bits
  localparam logic [27:0] P_1P5 = 28'h600_0000;  // 1.5
  localparam logic [27:0] P_1P25 = 28'h500_0000; // 1.25

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; start_i = 1'b0; prod_sign_i = 1'b0;
    prod_te_i = '0; prod_mant_i = '0; add_fir_i = '0;
    reset_model();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_zero",  zero_o, 1'b1);
    check("rst_fixed", fixed_o, 64'h0);
    rst_i = 1'b1;
    idle(2);

    // Basic FMA: 5.0 * ... product plus addend 10.0 = 15.0
    seen.delete();
    drive(1, 1, 0, 7'sd2, P_1P25, mkfir(0, 3, 14'h2800));
    idle(5);
    check("fma_pulses", seen.size(), 1);
    if (seen.size() > 0) begin
      check("fma_fixed", seen[0].fixed, 64'h0000_001E_0000_0000);
      check("fma_sign",  seen[0].sign, 1'b0);
      check("fma_te",    seen[0].te, 7'd3);
      check("fma_frac",  seen[0].frac, 40'hE0_0000_0000);
      check("fma_zero",  seen[0].zero, 1'b0);
    end

    // Cancellation: -1.0 + 1.0
    seen.delete();
    drive(1, 1, 1, 7'sd0, P_ONE, mkfir(0, 0, 14'h2000));
    idle(5);
    check("cancel_pulses", seen.size(), 1);
    if (seen.size() > 0) begin
      check("cancel_zero",  seen[0].zero, 1'b1);
      check("cancel_fixed", seen[0].fixed, 64'h0);
    end

    // Back-to-back accumulation of 1.0
    seen.delete();
    drive(1, 1, 0, 7'sd0, P_ONE, mkfir(0, 0, 14'h0));
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 7'sd0, P_ONE, mkfir(0, 0, 14'h0));
    idle(6);
    check("b2b_pulses", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check($sformatf("b2b_fixed%0d", i), seen[i].fixed, 64'(i + 1) << 33);

    // Saturation, sticky across accumulation, cleared by next start
    seen.delete();
    drive(1, 1, 0, 7'sd40, P_ONE, mkfir(0, 0, 14'h0));
    drive(1, 0, 0, 7'sd0, P_ONE, mkfir(0, 0, 14'h0));
    drive(1, 1, 0, 7'sd0, P_ONE, mkfir(0, 0, 14'h0));
    idle(5);
    check("sat_pulses", seen.size(), 3);
    if (seen.size() == 3) begin
      check("sat_fixed",   seen[0].fixed, 64'h7FFF_FFFF_FFFF_FFFF);
      check("sat_ovf",     seen[0].ovf, 1'b1);
      check("sat_hold",    seen[1].ovf, 1'b1);
      check("sat_clear",   seen[2].ovf, 1'b0);
      check("sat_restart", seen[2].fixed, 64'h2_0000_0000);
    end

    // Underflow truncation: 1.5 LSB of the fixed grid (te = -33)
    seen.delete();
    drive(1, 1, 0, -7'sd33, P_1P5, mkfir(0, 0, 14'h0));
    idle(5);
    check("uf_pulses", seen.size(), 1);
    if (seen.size() > 0) begin
      check("uf_fixed", seen[0].fixed, 64'h1);
      check("uf_trunc", seen[0].trunc, 1'b1);
      check("uf_te",    seen[0].te, 7'h5F);
    end

    // Reset one cycle after a valid product
    drive(1, 1, 0, 7'sd3, P_ONE, mkfir(0, 0, 14'h0));
    drive(1, 0, 0, 7'sd0, P_ONE, mkfir(0, 0, 14'h0));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    rst_i = 1'b0;
    reset_model();
    seen.delete();
    #1;
    check("midrst_valid", out_valid_o, 1'b0);
    check("midrst_zero",  zero_o, 1'b1);
    check("midrst_fixed", fixed_o, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle(5);
    check("midrst_pulses", seen.size(), 0);
    drive(1, 0, 0, 7'sd1, P_ONE, mkfir(0, 5, 14'h3FFF));
    idle(5);
    check("midrst_empty_pulses", seen.size(), 1);
    if (seen.size() > 0) check("midrst_empty_fixed", seen[0].fixed, 64'h4_0000_0000);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit v, st, ps;
      int pt, at;
      logic [27:0] pm;
      fir_t af;
      v  = ($urandom_range(3, 0) != 0);
      st = ($urandom_range(7, 0) == 0);
      ps = $urandom_range(1, 0) != 0;
      pt = ($urandom_range(15, 0) == 0) ? int'($urandom_range(127, 0)) - 64
                                        : int'($urandom_range(74, 0)) - 45;
      at = ($urandom_range(15, 0) == 0) ? int'($urandom_range(127, 0)) - 64
                                        : int'($urandom_range(70, 0)) - 45;
      pm = 28'($urandom);
      if ($urandom_range(1, 0) != 0) pm = {2'b01, pm[25:0]};
      af = mkfir($urandom_range(1, 0) != 0, at, 14'($urandom));
      drive(v, st, ps, 7'(pt), pm, af);
    end
    idle(6);
    check("drained", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
